// File: rtl/pipeline_perf_monitor.sv
// Performance monitor for the 5-stage pipeline: counts cycles, stalls, flushes and
// retired instructions, stops after a cycle budget, and serves counters over a read port.
module pipeline_perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             hazard_stall_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             flush_hazard_i,
    input  logic             flush_ifid_i,
    input  logic             retire_i,
    input  logic             rd_req_i,
    input  logic [1:0]       rd_sel_i,
    output logic             rd_ack_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             running_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] sel_value;
    logic             stall_ev;
    logic             flush_ev;
    logic             count_en;
    logic             last_cycle;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != ALL_ONES)) begin
            return v + ONE;
        end
        return v;
    endfunction

    // A stall that coincides with a jump/branch decode is a control bubble, not a data stall.
    assign stall_ev   = hazard_stall_i & ~jump_i & ~branch_i;
    assign flush_ev   = flush_hazard_i | flush_ifid_i;
    assign count_en   = (state == RUN) && start_i && !clear_i;
    assign last_cycle = (MAX_CYCLES != 0) && (cyc_cnt == LAST_CYC);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_i) next_state = RUN;
            RUN:     if (count_en && last_cycle) next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
        if (clear_i) next_state = IDLE;
    end

    always_comb begin
        sel_value = cyc_cnt;
        case (rd_sel_i)
            2'd0: sel_value = cyc_cnt;
            2'd1: sel_value = stall_cnt;
            2'd2: sel_value = flush_cnt;
            2'd3: sel_value = ret_cnt;
            default: sel_value = cyc_cnt;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            ret_cnt   <= '0;
        end else if (clear_i) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            ret_cnt   <= '0;
        end else if (count_en) begin
            cyc_cnt   <= sat_inc(cyc_cnt, 1'b1);
            stall_cnt <= sat_inc(stall_cnt, stall_ev);
            flush_cnt <= sat_inc(flush_cnt, flush_ev);
            ret_cnt   <= sat_inc(ret_cnt, retire_i);
        end
    end

    // The read snapshot uses the counter values before this edge's update (and before clear).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ack_o  <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_ack_o <= rd_req_i;
            if (rd_req_i) begin
                rd_data_o <= sel_value;
            end
        end
    end

    assign running_o = (state == RUN);
    assign done_o    = (state == DONE);

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed testbench for pipeline_perf_monitor: a 32-bit/30-cycle instance and a
// 4-bit/free-running instance share the same stimulus.
module tb_pipeline_perf_monitor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        clear_i;
    logic        hazard_stall_i;
    logic        jump_i;
    logic        branch_i;
    logic        flush_hazard_i;
    logic        flush_ifid_i;
    logic        retire_i;
    logic        rd_req_i;
    logic [1:0]  rd_sel_i;

    logic        rd_ack_a;
    logic [31:0] rd_data_a;
    logic        running_a;
    logic        done_a;
    logic        rd_ack_b;
    logic [3:0]  rd_data_b;
    logic        running_b;
    logic        done_b;

    int checks = 0;
    int passes = 0;

    always #5 clk_i = ~clk_i;

    pipeline_perf_monitor #(.CNT_W(32), .MAX_CYCLES(30)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .hazard_stall_i(hazard_stall_i), .jump_i(jump_i), .branch_i(branch_i),
        .flush_hazard_i(flush_hazard_i), .flush_ifid_i(flush_ifid_i),
        .retire_i(retire_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
        .rd_ack_o(rd_ack_a), .rd_data_o(rd_data_a),
        .running_o(running_a), .done_o(done_a)
    );

    pipeline_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .hazard_stall_i(hazard_stall_i), .jump_i(jump_i), .branch_i(branch_i),
        .flush_hazard_i(flush_hazard_i), .flush_ifid_i(flush_ifid_i),
        .retire_i(retire_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
        .rd_ack_o(rd_ack_b), .rd_data_o(rd_data_b),
        .running_o(running_b), .done_o(done_b)
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        start_i = 1'b0;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0; hazard_stall_i = 1'b0;
        jump_i = 1'b0; branch_i = 1'b0; flush_hazard_i = 1'b0; flush_ifid_i = 1'b0;
        retire_i = 1'b0; rd_req_i = 1'b0; rd_sel_i = 2'd0;
        tick();
        tick();
        checks++; if (rd_ack_a !== 1'b0) $display("[TB] FAIL reset_ack: got %0b expected 0", rd_ack_a); else passes++;
        checks++; if (rd_data_a !== 32'd0) $display("[TB] FAIL reset_data: got %0d expected 0", rd_data_a); else passes++;
        checks++; if (running_a !== 1'b0) $display("[TB] FAIL reset_running: got %0b expected 0", running_a); else passes++;
        checks++; if (done_a !== 1'b0) $display("[TB] FAIL reset_done: got %0b expected 0", done_a); else passes++;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_budget();
        start_i = 1'b1;
        tick();
        checks++; if (running_a !== 1'b1) $display("[TB] FAIL budget_enter_run: got %0b expected 1", running_a); else passes++;
        repeat (29) tick();
        checks++; if (done_a !== 1'b0) $display("[TB] FAIL budget_early_done: got %0b expected 0", done_a); else passes++;
        tick();
        checks++; if (done_a !== 1'b1) $display("[TB] FAIL budget_done: got %0b expected 1", done_a); else passes++;
        checks++; if (running_a !== 1'b0) $display("[TB] FAIL budget_running_low: got %0b expected 0", running_a); else passes++;
        rd_req_i = 1'b1; rd_sel_i = 2'd0;
        tick();
        checks++; if (rd_ack_a !== 1'b1) $display("[TB] FAIL budget_read_ack: got %0b expected 1", rd_ack_a); else passes++;
        checks++; if (rd_data_a !== 32'd30) $display("[TB] FAIL budget_cyc: got %0d expected 30", rd_data_a); else passes++;
        checks++; if (done_a !== 1'b1) $display("[TB] FAIL budget_done_sticky: got %0b expected 1", done_a); else passes++;
        rd_req_i = 1'b0;
        tick();
        checks++; if (rd_ack_a !== 1'b0) $display("[TB] FAIL budget_ack_drop: got %0b expected 0", rd_ack_a); else passes++;
        checks++; if (rd_data_a !== 32'd30) $display("[TB] FAIL budget_data_hold: got %0d expected 30", rd_data_a); else passes++;
        do_clear();
        checks++; if (done_a !== 1'b0) $display("[TB] FAIL budget_clear_done: got %0b expected 0", done_a); else passes++;
    endtask

    task automatic test_stall();
        start_i = 1'b1;
        tick();
        hazard_stall_i = 1'b1;
        tick();
        branch_i = 1'b1;
        tick();
        branch_i = 1'b0;
        tick();
        hazard_stall_i = 1'b0; jump_i = 1'b1;
        tick();
        jump_i = 1'b0; start_i = 1'b0;
        rd_req_i = 1'b1; rd_sel_i = 2'd1;
        tick();
        rd_req_i = 1'b0;
        checks++; if (rd_data_a !== 32'd2) $display("[TB] FAIL stall_count: got %0d expected 2", rd_data_a); else passes++;
        do_clear();
    endtask

    task automatic test_flush();
        start_i = 1'b1;
        tick();
        flush_hazard_i = 1'b1; flush_ifid_i = 1'b1;
        tick();
        flush_hazard_i = 1'b0;
        tick();
        flush_ifid_i = 1'b0;
        tick();
        start_i = 1'b0;
        rd_req_i = 1'b1; rd_sel_i = 2'd2;
        tick();
        rd_req_i = 1'b0;
        checks++; if (rd_data_a !== 32'd2) $display("[TB] FAIL flush_count: got %0d expected 2", rd_data_a); else passes++;
        do_clear();
    endtask

    task automatic test_pause();
        start_i = 1'b1;
        tick();
        retire_i = 1'b1;
        repeat (3) tick();
        start_i = 1'b0;
        repeat (3) tick();
        checks++; if (running_a !== 1'b1) $display("[TB] FAIL pause_running: got %0b expected 1", running_a); else passes++;
        rd_req_i = 1'b1; rd_sel_i = 2'd0;
        tick();
        checks++; if (rd_data_a !== 32'd3) $display("[TB] FAIL pause_cyc: got %0d expected 3", rd_data_a); else passes++;
        rd_sel_i = 2'd3;
        tick();
        checks++; if (rd_data_a !== 32'd3) $display("[TB] FAIL pause_ret: got %0d expected 3", rd_data_a); else passes++;
        rd_req_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0; rd_req_i = 1'b1; rd_sel_i = 2'd3;
        tick();
        checks++; if (rd_data_a !== 32'd4) $display("[TB] FAIL pause_resume_ret: got %0d expected 4", rd_data_a); else passes++;
        rd_req_i = 1'b0; retire_i = 1'b0;
        do_clear();
    endtask

    task automatic test_back_to_back();
        start_i = 1'b1;
        tick();
        hazard_stall_i = 1'b1; retire_i = 1'b1;
        rd_req_i = 1'b1; rd_sel_i = 2'd0;
        tick();
        checks++; if (rd_ack_a !== 1'b1) $display("[TB] FAIL b2b_ack0: got %0b expected 1", rd_ack_a); else passes++;
        checks++; if (rd_data_a !== 32'd0) $display("[TB] FAIL b2b_cyc_snapshot: got %0d expected 0", rd_data_a); else passes++;
        rd_sel_i = 2'd1;
        tick();
        checks++; if (rd_ack_a !== 1'b1) $display("[TB] FAIL b2b_ack1: got %0b expected 1", rd_ack_a); else passes++;
        checks++; if (rd_data_a !== 32'd1) $display("[TB] FAIL b2b_stall_snapshot: got %0d expected 1", rd_data_a); else passes++;
        rd_sel_i = 2'd3;
        tick();
        checks++; if (rd_ack_a !== 1'b1) $display("[TB] FAIL b2b_ack2: got %0b expected 1", rd_ack_a); else passes++;
        checks++; if (rd_data_a !== 32'd2) $display("[TB] FAIL b2b_ret_snapshot: got %0d expected 2", rd_data_a); else passes++;
        hazard_stall_i = 1'b0; retire_i = 1'b0;
        rd_sel_i = 2'd0; clear_i = 1'b1;
        tick();
        clear_i = 1'b0; start_i = 1'b0;
        checks++; if (rd_data_a !== 32'd3) $display("[TB] FAIL clear_read_old: got %0d expected 3", rd_data_a); else passes++;
        checks++; if (running_a !== 1'b0) $display("[TB] FAIL clear_to_idle: got %0b expected 0", running_a); else passes++;
        tick();
        checks++; if (rd_data_a !== 32'd0) $display("[TB] FAIL clear_read_new: got %0d expected 0", rd_data_a); else passes++;
        rd_req_i = 1'b0;
        tick();
    endtask

    task automatic test_saturate_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        start_i = 1'b1;
        tick();
        hazard_stall_i = 1'b1; retire_i = 1'b1;
        repeat (20) tick();
        checks++; if (done_b !== 1'b0) $display("[TB] FAIL sat_no_done: got %0b expected 0", done_b); else passes++;
        checks++; if (running_b !== 1'b1) $display("[TB] FAIL sat_running: got %0b expected 1", running_b); else passes++;
        rd_req_i = 1'b1; rd_sel_i = 2'd0;
        tick();
        checks++; if (rd_data_b !== 4'd15) $display("[TB] FAIL sat_cyc: got %0d expected 15", rd_data_b); else passes++;
        rd_sel_i = 2'd3;
        tick();
        checks++; if (rd_ack_b !== 1'b1) $display("[TB] FAIL sat_ack: got %0b expected 1", rd_ack_b); else passes++;
        checks++; if (rd_data_b !== 4'd15) $display("[TB] FAIL sat_ret: got %0d expected 15", rd_data_b); else passes++;
        #2 rst_i = 1'b1;
        #1;
        checks++; if (rd_ack_b !== 1'b0) $display("[TB] FAIL rst_mid_ack: got %0b expected 0", rd_ack_b); else passes++;
        checks++; if (rd_data_b !== 4'd0) $display("[TB] FAIL rst_mid_data: got %0d expected 0", rd_data_b); else passes++;
        checks++; if (running_b !== 1'b0) $display("[TB] FAIL rst_mid_running: got %0b expected 0", running_b); else passes++;
        rd_req_i = 1'b0; start_i = 1'b0; hazard_stall_i = 1'b0; retire_i = 1'b0;
        tick();
        rst_i = 1'b0;
        rd_req_i = 1'b1; rd_sel_i = 2'd0;
        tick();
        checks++; if (rd_data_b !== 4'd0) $display("[TB] FAIL rst_cyc_zero: got %0d expected 0", rd_data_b); else passes++;
        rd_sel_i = 2'd1;
        tick();
        checks++; if (rd_data_b !== 4'd0) $display("[TB] FAIL rst_stall_zero: got %0d expected 0", rd_data_b); else passes++;
        rd_sel_i = 2'd3;
        tick();
        checks++; if (rd_data_b !== 4'd0) $display("[TB] FAIL rst_ret_zero: got %0d expected 0", rd_data_b); else passes++;
        rd_req_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_budget();
        test_stall();
        test_flush();
        test_pause();
        test_back_to_back();
        test_saturate_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
